time_unit_counter: RTL and testbench

Parametrised, cascadable time-of-day/calendar field counter, the generalised successor to the fixed minute counter. One instance per field (second, minute, hour, day, month, year). Each instance advances on a falling edge of the lower field's carry and wraps between a configurable minimum and a static or run-time maximum. It emits a one-cycle carry pulse to the next field and supports user modify (plus/minus) when its field is selected.

---
 rtl/time_unit_counter.sv | 154 +++++++++++++++
 tb/tb_time_unit_counter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/time_unit_counter.sv
// time_unit_counter: one cascadable field (second/minute/hour/day/month/year)
// of a time-of-day/calendar chain. Advances on the falling edge of the lower
// field's carry, wraps between MIN_VALUE and i_max, and accepts plus/minus
// modify steps when this field is selected.
// Optional feature macro: TIME_UNIT_AUTOREPEAT_EN (hold-to-repeat on buttons).
module time_unit_counter #(
  parameter int WIDTH         = 15,
  parameter int MIN_VALUE     = 0,
  parameter int FIELD_ID      = 1,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic             i_clk_0_001s,
  input  logic             i_rst_n,
  input  logic [4:0]       i_state,
  input  logic             i_modify,
  input  logic             i_plus,
  input  logic             i_minus,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_max,
  output logic [WIDTH-1:0] o_value,
  output logic             o_carry
);

  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VALUE);

  logic             enable_q, plus_q, minus_q;
  logic             enable_fall, plus_fall, minus_fall;
  logic             selected;
  logic             up_evt, down_evt;
  logic [WIDTH-1:0] value_next;
  logic             carry_next;

  assign selected = i_modify && (i_state == 5'(FIELD_ID));

  // Register each input once and flag falling edges (prev high, now low).
  always_ff @(posedge i_clk_0_001s or negedge i_rst_n) begin
    if (!i_rst_n) begin
      enable_q    <= 1'b0;
      plus_q      <= 1'b0;
      minus_q     <= 1'b0;
      enable_fall <= 1'b0;
      plus_fall   <= 1'b0;
      minus_fall  <= 1'b0;
    end else begin
      enable_q    <= i_enable;
      plus_q      <= i_plus;
      minus_q     <= i_minus;
      enable_fall <= enable_q & ~i_enable;
      plus_fall   <= plus_q & ~i_plus;
      minus_fall  <= minus_q & ~i_minus;
    end
  end

`ifdef TIME_UNIT_AUTOREPEAT_EN
  // Timer is sized for the larger of the two repeat intervals.
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW      = (RPT_MAX < 2) ? 1 : $clog2(RPT_MAX + 1);

  // Index 0 = plus button, index 1 = minus button.
  logic [1:0]    btn_raw, btn_fall;
  logic [1:0]    holding, fired, rep_flag;
  logic [TW-1:0] rpt_timer [2];

  assign btn_raw  = {i_minus, i_plus};
  assign btn_fall = {minus_fall, plus_fall};

  // Per-button hold timer: down-counter that fires a repeat step when it
  // reaches terminal count, first after REPEAT_DELAY held cycles and then
  // every REPEAT_PERIOD cycles. 'fired' remembers that a repeat happened so
  // the release edge does not add one more step.
  always_ff @(posedge i_clk_0_001s or negedge i_rst_n) begin
    if (!i_rst_n) begin
      holding  <= '0;
      fired    <= '0;
      rep_flag <= '0;
      for (int b = 0; b < 2; b++) rpt_timer[b] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (!selected) begin
          holding[b]   <= 1'b0;
          fired[b]     <= 1'b0;
          rep_flag[b]  <= 1'b0;
          rpt_timer[b] <= '0;
        end else if (btn_raw[b]) begin
          holding[b] <= 1'b1;
          if (!holding[b]) begin
            if (REPEAT_DELAY <= 1) begin
              rep_flag[b]  <= 1'b1;
              fired[b]     <= 1'b1;
              rpt_timer[b] <= TW'(REPEAT_PERIOD);
            end else begin
              rep_flag[b]  <= 1'b0;
              rpt_timer[b] <= TW'(REPEAT_DELAY - 1);
              if (btn_fall[b]) fired[b] <= 1'b0;
            end
          end else if (rpt_timer[b] <= TW'(1)) begin
            rep_flag[b]  <= 1'b1;
            fired[b]     <= 1'b1;
            rpt_timer[b] <= TW'(REPEAT_PERIOD);
          end else begin
            rep_flag[b]  <= 1'b0;
            rpt_timer[b] <= rpt_timer[b] - TW'(1);
          end
        end else begin
          holding[b]   <= 1'b0;
          rep_flag[b]  <= 1'b0;
          rpt_timer[b] <= '0;
          if (btn_fall[b]) fired[b] <= 1'b0;
        end
      end
    end
  end

  assign up_evt   = selected && ((plus_fall && !fired[0]) || rep_flag[0]);
  assign down_evt = selected && ((minus_fall && !fired[1]) || rep_flag[1]);
`else
  assign up_evt   = selected && plus_fall;
  assign down_evt = selected && minus_fall;
`endif

  // Next count: carry-in step beats modify; simultaneous plus/minus holds;
  // otherwise pull an out-of-range value down to the new maximum.
  always_comb begin
    value_next = o_value;
    carry_next = 1'b0;
    if (enable_fall) begin
      if (o_value >= i_max) begin
        value_next = MIN_V;
        carry_next = 1'b1;
      end else begin
        value_next = o_value + WIDTH'(1);
      end
    end else if (up_evt && !down_evt) begin
      value_next = (o_value >= i_max) ? MIN_V : o_value + WIDTH'(1);
    end else if (down_evt && !up_evt) begin
      value_next = (o_value <= MIN_V || o_value > i_max) ? i_max : o_value - WIDTH'(1);
    end else if (o_value > i_max) begin
      value_next = i_max;
    end
  end

  // Count and carry-out registers.
  always_ff @(posedge i_clk_0_001s or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_value <= MIN_V;
      o_carry <= 1'b0;
    end else begin
      o_value <= value_next;
      o_carry <= carry_next;
    end
  end

endmodule

// File: tb/tb_time_unit_counter.sv
// Bench for time_unit_counter: two instances (MIN_VALUE 0 and 1) share
// buttons/state, each with its own maximum. Stimulus pushes the expected
// per-edge outputs into a queue; a monitor pops and compares after each edge.
module tb_time_unit_counter;
  localparam int W   = 8;
  localparam int FID = 3;
  localparam int RD  = 5;
  localparam int RP  = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [4:0]   st = '0;
  logic         md = 1'b0, pl = 1'b0, mn = 1'b0, en = 1'b0;
  logic [W-1:0] max0 = 8'd59, max1 = 8'd28;
  logic [W-1:0] v0, v1;
  logic         c0, c1;

  always #5 clk = ~clk;

  time_unit_counter #(.WIDTH(W), .MIN_VALUE(0), .FIELD_ID(FID),
                      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u_f0 (
    .i_clk_0_001s(clk), .i_rst_n(rst_n), .i_state(st), .i_modify(md),
    .i_plus(pl), .i_minus(mn), .i_enable(en), .i_max(max0),
    .o_value(v0), .o_carry(c0));

  time_unit_counter #(.WIDTH(W), .MIN_VALUE(1), .FIELD_ID(FID),
                      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u_f1 (
    .i_clk_0_001s(clk), .i_rst_n(rst_n), .i_state(st), .i_modify(md),
    .i_plus(pl), .i_minus(mn), .i_enable(en), .i_max(max1),
    .o_value(v1), .o_carry(c1));

  typedef struct {
    int v0; int c0; int v1; int c1;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  // Values applied at the next negedge
  logic [4:0]   nx_st = '0;
  logic         nx_md = 1'b0, nx_rst = 1'b0;
  logic [W-1:0] nx_max0 = 8'd59, nx_max1 = 8'd28;

  // Reference model: count per field plus button/enable history.
  int mv[2];
  int mc[2];
  bit p_en, p_pl, p_mn;
  bit q_en, q_pl, q_mn;
  int k_pl, k_mn;
  bit f_pl, f_mn, r_pl, r_mn;

  function automatic void check(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endfunction

  function automatic bit rep_due(int k);
    return (k == RD) || (k > RD && ((k - RD) % RP) == 0);
  endfunction

  // Predict outputs after the coming rising edge from the inputs just driven.
  function automatic void model_edge();
    bit sel = md && (st == 5'(FID));
    bit up, dn;
    int lo, hi, span;
    if (!rst_n) begin
      mv[0] = 0; mv[1] = 1; mc[0] = 0; mc[1] = 0;
      p_en = 0; p_pl = 0; p_mn = 0; q_en = 0; q_pl = 0; q_mn = 0;
      k_pl = 0; k_mn = 0; f_pl = 0; f_mn = 0; r_pl = 0; r_mn = 0;
      return;
    end
`ifdef TIME_UNIT_AUTOREPEAT_EN
    up = sel && ((q_pl && !f_pl) || r_pl);
    dn = sel && ((q_mn && !f_mn) || r_mn);
`else
    up = sel && q_pl;
    dn = sel && q_mn;
`endif
    for (int k = 0; k < 2; k++) begin
      lo = k;
      hi = (k == 0) ? int'(max0) : int'(max1);
      span = hi - lo + 1;
      mc[k] = 0;
      if (q_en) begin
        if (mv[k] >= hi) begin mv[k] = lo; mc[k] = 1; end
        else mv[k] = mv[k] + 1;
      end else if (up && !dn) begin
        mv[k] = (mv[k] > hi) ? lo : lo + ((mv[k] - lo + 1) % span);
      end else if (dn && !up) begin
        mv[k] = (mv[k] > hi) ? hi : lo + ((mv[k] - lo + span - 1) % span);
      end else if (mv[k] > hi) begin
        mv[k] = hi;
      end
    end
`ifdef TIME_UNIT_AUTOREPEAT_EN
    if (q_pl) f_pl = 0;
    if (sel && pl) begin k_pl++; r_pl = rep_due(k_pl); if (r_pl) f_pl = 1; end
    else begin k_pl = 0; r_pl = 0; if (!sel) f_pl = 0; end
    if (q_mn) f_mn = 0;
    if (sel && mn) begin k_mn++; r_mn = rep_due(k_mn); if (r_mn) f_mn = 1; end
    else begin k_mn = 0; r_mn = 0; if (!sel) f_mn = 0; end
`endif
    q_en = p_en && !en; q_pl = p_pl && !pl; q_mn = p_mn && !mn;
    p_en = en; p_pl = pl; p_mn = mn;
  endfunction

  task automatic drive(input logic e, input logic p, input logic m, input int n);
    exp_t x;
    repeat (n) begin
      @(negedge clk);
      en = e; pl = p; mn = m;
      st = nx_st; md = nx_md; max0 = nx_max0; max1 = nx_max1; rst_n = nx_rst;
      model_edge();
      x.v0 = mv[0]; x.c0 = mc[0]; x.v1 = mv[1]; x.c1 = mc[1];
      sb.push_back(x);
    end
  endtask

  // Monitor: one expected record per rising edge once stimulus has started.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_v0", int'(v0), e.v0);
      check("sb_c0", int'(c0), e.c0);
      check("sb_v1", int'(v1), e.v1);
      check("sb_c1", int'(c1), e.c1);
    end
  end

  initial begin
    logic r_en, r_pl, r_mn;
    // Reset state
    nx_rst = 0;
    drive(0, 0, 0, 2);
    nx_rst = 1; nx_st = 5'(FID); nx_md = 1; nx_max0 = 59; nx_max1 = 28;
    drive(0, 0, 0, 2);
    check("reset_v0", int'(v0), 0);
    check("reset_v1", int'(v1), 1);

    // Modify: minus wraps to max, plus wraps back to min
    drive(0, 0, 1, 2); drive(0, 0, 0, 3);
    check("mod_minus_v0", int'(v0), 59);
    check("mod_minus_v1", int'(v1), 28);
    drive(0, 1, 0, 2); drive(0, 0, 0, 3);
    check("mod_plus_v0", int'(v0), 0);
    check("mod_plus_v1", int'(v1), 1);

    // Down to 58, then cascade 58 -> 59 -> 0 with carry
    drive(0, 0, 1, 2); drive(0, 0, 0, 3);
    drive(0, 0, 1, 2); drive(0, 0, 0, 3);
    check("pre_cascade_v0", int'(v0), 58);
    drive(1, 0, 0, 2); drive(0, 0, 0, 1);
    drive(1, 0, 0, 2);
    check("cascade_first_v0", int'(v0), 59);
    drive(0, 0, 0, 3);
    check("cascade_wrap_v0", int'(v0), 0);
    check("day_wrap_v1", int'(v1), 1);

    // Day clamp 31 -> 30 when the maximum drops
    nx_max1 = 31;
    drive(0, 0, 1, 2); drive(0, 0, 0, 3);
    check("day31_v1", int'(v1), 31);
    nx_max1 = 30;
    drive(0, 0, 0, 2);
    check("day_clamp_v1", int'(v1), 30);

    // Enable and plus falling together: only the carry step
    drive(1, 1, 0, 2); drive(0, 0, 0, 3);
    check("collide_en_plus_v0", int'(v0), 0);
    // Plus and minus together: hold
    drive(0, 1, 1, 2); drive(0, 0, 0, 3);
    check("collide_plus_minus_v0", int'(v0), 0);
    // Other field selected: ignored
    nx_st = 5'(FID + 1);
    drive(0, 1, 0, 2); drive(0, 0, 0, 3);
    check("unselected_v0", int'(v0), 0);
    nx_st = 5'(FID);

    // Reset with a pending enable flag at value 37
    drive(0, 0, 1, 2); drive(0, 0, 0, 3);
    drive(0, 0, 1, 2); drive(0, 0, 0, 3);
    nx_max0 = 37;
    drive(0, 0, 0, 2);
    nx_max0 = 59;
    drive(1, 0, 0, 2); drive(0, 0, 0, 1);
    check("rst_pre_v0", int'(v0), 37);
    nx_rst = 0;
    drive(0, 0, 0, 1);
    #1;
    check("rst_async_v0", int'(v0), 0);
    check("rst_async_c0", int'(c0), 0);
    check("rst_async_v1", int'(v1), 1);
    drive(0, 0, 0, 2);
    nx_rst = 1;
    drive(0, 0, 0, 4);
    check("rst_nostep_v0", int'(v0), 0);

    // Randomised phase
    r_en = 0; r_pl = 0; r_mn = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) r_en = ~r_en;
      if ($urandom_range(0, 3) == 0) r_pl = ~r_pl;
      if ($urandom_range(0, 3) == 0) r_mn = ~r_mn;
      nx_st = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'(FID);
      nx_md = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 49) == 0) nx_max0 = W'($urandom_range(0, 59));
      if ($urandom_range(0, 49) == 0) nx_max1 = W'($urandom_range(28, 31));
      nx_rst = ($urandom_range(0, 299) != 0);
      drive(r_en, r_pl, r_mn, 1);
    end

`ifdef TIME_UNIT_AUTOREPEAT_EN
    // Hold plus 12 cycles from 10: repeats at 5, 8, 11, none on release
    nx_rst = 0;
    drive(0, 0, 0, 2);
    nx_rst = 1; nx_st = 5'(FID); nx_md = 1; nx_max0 = 59; nx_max1 = 31;
    drive(0, 0, 0, 2);
    drive(0, 0, 1, 1); drive(0, 0, 0, 3);
    nx_max0 = 10;
    drive(0, 0, 0, 2);
    nx_max0 = 59;
    drive(0, 0, 0, 1);
    check("rpt_start_v0", int'(v0), 10);
    drive(0, 1, 0, 12); drive(0, 0, 0, 4);
    check("rpt_hold_v0", int'(v0), 13);
`endif

    drive(0, 0, 0, 2);
    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
